output_accum_buffer: RTL and testbench

Parametrised output buffer for the systolic array. It captures skewed per-column results from the array's bottom edge into a COLS x DEPTH tile store and can accumulate successive K-partial tiles into that store. It then drains the finished tile row by row over a ready/valid stream toward writeback. It sits between the PE array outputs and the result memory interface.

---
 rtl/output_accum_buffer_if.sv | 31 +++
 rtl/output_accum_buffer.sv | 157 +++++++++++++++
 tb/tb_output_accum_buffer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_accum_buffer_if.sv
// Stream bundle for the output accumulation buffer:
// array beats in, drained tile rows out.
interface output_accum_buffer_if #(
  parameter int COLS   = 8,
  parameter int DATA_W = 32
);
  logic                   in_valid;
  logic [COLS*DATA_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [COLS*DATA_W-1:0] out_data;
  logic                   out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_last
  );
endinterface

// File: rtl/output_accum_buffer.sv
// Tile store for skewed systolic array results with optional
// accumulation of K-partial tiles and row-wise ready/valid drain.
module output_accum_buffer #(
  parameter int COLS     = 8,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int COL_SKEW = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic start,
  input  logic start_acc,
  input  logic drain_req,
  output logic busy,
  output logic tile_ready,
  output logic err,
  output_accum_buffer_if.slave bus
);

  localparam int LOAD_BEATS = DEPTH + COL_SKEW * (COLS - 1);
  localparam int LC_W = $clog2(LOAD_BEATS);
  localparam int RP_W = $clog2(DEPTH);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LOAD_BEATS - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    DRAIN
  } state_t;

  state_t                 state;
  logic [LC_W-1:0]        lc;
  logic [RP_W-1:0]        rp;
  logic                   acc;
  logic                   ov;
  logic                   ol;
  logic [COLS*DATA_W-1:0] od;
  logic                   ld_beat;
  int                     lc_i;
  logic [RP_W-1:0]        rd_ptr;
  logic [DATA_W-1:0]      rd_word [COLS];
  logic [COLS*DATA_W-1:0] rd_row;

  assign ld_beat = (state == LOAD) && bus.in_valid;
  assign lc_i    = int'(lc);

  // While a beat is pending, look ahead to the row that follows it.
  assign rd_ptr = ov ? rp + RP_W'(1) : rp;

  for (genvar g = 0; g < COLS; g++) begin : g_col
    localparam int OFF = COL_SKEW * g;

    logic [DATA_W-1:0] col_mem [DEPTH];
    logic              wr_en;
    logic [RP_W-1:0]   wr_row;
    logic [DATA_W-1:0] slice;
    logic [DATA_W-1:0] wr_val;

    assign slice  = bus.in_data[g*DATA_W +: DATA_W];
    assign wr_en  = ld_beat && (lc_i >= OFF) && (lc_i < OFF + DEPTH);
    assign wr_row = RP_W'(lc_i - OFF);
    assign wr_val = acc ? col_mem[wr_row] + slice : slice;
    assign rd_word[g] = col_mem[rd_ptr];

    // Column store: each (col,row) written once per tile, RMW in one cycle.
    always_ff @(posedge clk) begin
      if (wr_en) col_mem[wr_row] <= wr_val;
    end
  end

  // Pack the per-column read words into one output row.
  always_comb begin
    rd_row = '0;
    for (int i = 0; i < COLS; i++) begin
      rd_row[i*DATA_W +: DATA_W] = rd_word[i];
    end
  end

  // Control FSM with registered drain stream and error pulse.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= IDLE;
      lc    <= '0;
      rp    <= '0;
      acc   <= 1'b0;
      ov    <= 1'b0;
      ol    <= 1'b0;
      od    <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (drain_req) err <= 1'b1;
          if (start) begin
            state <= LOAD;
            acc   <= 1'b0;
            lc    <= '0;
          end
        end
        LOAD: begin
          if (start || drain_req) err <= 1'b1;
          if (bus.in_valid) begin
            if (lc == LC_LAST) begin
              state <= HOLD;
              lc    <= '0;
            end else begin
              lc <= lc + LC_W'(1);
            end
          end
        end
        HOLD: begin
          if (drain_req) begin
            state <= DRAIN;
            rp    <= '0;
            if (start) err <= 1'b1;
          end else if (start) begin
            state <= LOAD;
            acc   <= start_acc;
            lc    <= '0;
          end
        end
        DRAIN: begin
          if (start || drain_req) err <= 1'b1;
          if (!ov) begin
            ov <= 1'b1;
            od <= rd_row;
            ol <= (rp == RP_LAST);
          end else if (bus.out_ready) begin
            if (ol) begin
              state <= IDLE;
              ov    <= 1'b0;
              ol    <= 1'b0;
              od    <= '0;
              rp    <= '0;
            end else begin
              rp <= rp + RP_W'(1);
              od <= rd_row;
              ol <= (rp + RP_W'(1) == RP_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy          = (state == LOAD) || (state == DRAIN);
  assign tile_ready    = (state == HOLD);
  assign bus.out_valid = ov;
  assign bus.out_last  = ol;
  assign bus.out_data  = od;

endmodule

// File: tb/tb_output_accum_buffer.sv
// Self-checking bench for output_accum_buffer:
// tile load, accumulate, drain backpressure, commands, abort.
module tb_output_accum_buffer;
  localparam int COLS  = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SKEW  = 3;
  localparam int BEATS = DEPTH + SKEW * (COLS - 1);
  localparam int W     = COLS * DW;

  logic clk = 1'b0;
  logic rst, clear, start, start_acc, drain_req;
  logic busy, tile_ready, err;

  output_accum_buffer_if #(.COLS(COLS), .DATA_W(DW)) bus ();

  output_accum_buffer #(
    .COLS(COLS),
    .DATA_W(DW),
    .DEPTH(DEPTH),
    .COL_SKEW(SKEW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .start(start),
    .start_acc(start_acc),
    .drain_req(drain_req),
    .busy(busy),
    .tile_ready(tile_ready),
    .err(err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    int setup;
    bit st;
    bit sa;
    bit dr;
    bit e_err;
    bit e_busy;
    bit e_tr;
  } cmd_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } acc_t;

  beat_t       sb [$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [COLS][DEPTH];
  logic        prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic        prev_last;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    beat_t e;
    if (prev_stall) begin
      chk("stall_valid", W'(bus.out_valid), W'(1));
      chk("stall_data", bus.out_data, prev_data);
      chk("stall_last", W'(bus.out_last), W'(prev_last));
    end
    if (!bus.out_valid) chk("idle_data_zero", bus.out_data, '0);
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none", bus.out_data);
      end else begin
        e = sb.pop_front();
        chk("beat_data", bus.out_data, e.data);
        chk("beat_last", W'(bus.out_last), W'(e.last));
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    prev_last  = bus.out_last;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tile(input bit acc_in, input bit eff_acc,
                           input bit gaps, input bit pat,
                           input logic [31:0] w);
    logic [31:0] v;
    start = 1'b1;
    start_acc = acc_in;
    tick();
    start = 1'b0;
    start_acc = 1'b0;
    chk("load_busy", W'(busy), W'(1));
    for (int n = 0; n < BEATS; n++) begin
      bus.in_valid = 1'b1;
      for (int i = 0; i < COLS; i++)
        bus.in_data[i*DW +: DW] = pat ? 32'(100 * i + n) : w;
      tick();
      if (gaps) begin
        bus.in_valid = 1'b0;
        bus.in_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
      end
      if (n == BEATS - 2) begin
        chk("load_not_done_busy", W'(busy), W'(1));
        chk("load_not_done_tr", W'(tile_ready), W'(0));
      end
    end
    bus.in_valid = 1'b0;
    if (gaps) tick();
    chk("load_done_tr", W'(tile_ready), W'(1));
    chk("load_done_busy", W'(busy), W'(0));
    for (int i = 0; i < COLS; i++)
      for (int r = 0; r < DEPTH; r++) begin
        v = pat ? 32'(100 * i + r + SKEW * i) : w;
        model[i][r] = eff_acc ? model[i][r] + v : v;
      end
  endtask

  task automatic drain(input bit alt);
    beat_t b;
    int    cyc;
    for (int r = 0; r < DEPTH; r++) begin
      for (int i = 0; i < COLS; i++) b.data[i*DW +: DW] = model[i][r];
      b.last = (r == DEPTH - 1);
      sb.push_back(b);
    end
    bus.out_ready = 1'b1;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    chk("drain_busy", W'(busy), W'(1));
    cyc = 0;
    while (sb.size() > 0 && cyc < 50) begin
      if (alt) bus.out_ready = ~bus.out_ready;
      tick();
      cyc++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d rows left expected 0", sb.size());
      sb.delete();
    end
    chk("drain_end_valid", W'(bus.out_valid), W'(0));
    chk("drain_end_busy", W'(busy), W'(0));
    bus.out_ready = 1'b1;
  endtask

  initial begin
    cmd_t cmds [7];
    acc_t accs [3];

    cmds[0] = '{0, 0, 0, 1, 1, 0, 0};
    cmds[1] = '{0, 1, 1, 0, 0, 1, 0};
    cmds[2] = '{2, 1, 0, 1, 1, 1, 0};
    cmds[3] = '{2, 0, 0, 1, 0, 1, 0};
    cmds[4] = '{2, 1, 1, 0, 0, 1, 0};
    cmds[5] = '{1, 1, 0, 0, 1, 1, 0};
    cmds[6] = '{1, 0, 0, 1, 1, 1, 0};

    accs[0] = '{32'd5, 32'd7, 32'd12};
    accs[1] = '{32'd5, 32'hFFFF_FFFF, 32'd4};
    accs[2] = '{32'h8000_0000, 32'h8000_0001, 32'd1};

    rst = 1'b1;
    clear = 1'b0;
    start = 1'b0;
    start_acc = 1'b0;
    drain_req = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", W'(bus.out_valid), W'(0));
    chk("rst_last", W'(bus.out_last), W'(0));
    chk("rst_data", bus.out_data, '0);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_tr", W'(tile_ready), W'(0));
    chk("rst_err", W'(err), W'(0));

    // Contiguous overwrite load, full-rate drain.
    load_tile(0, 0, 0, 1, 32'd0);
    drain(0);

    // Command handling from each state.
    for (int k = 0; k < 7; k++) begin
      if (cmds[k].setup == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end else if (cmds[k].setup == 2) begin
        load_tile(0, 0, 0, 1, 32'd0);
      end
      start = cmds[k].st;
      start_acc = cmds[k].sa;
      drain_req = cmds[k].dr;
      tick();
      start = 1'b0;
      start_acc = 1'b0;
      drain_req = 1'b0;
      chk($sformatf("cmd%0d_err", k), W'(err), W'(cmds[k].e_err));
      chk($sformatf("cmd%0d_busy", k), W'(busy), W'(cmds[k].e_busy));
      chk($sformatf("cmd%0d_tr", k), W'(tile_ready), W'(cmds[k].e_tr));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk($sformatf("cmd%0d_clr_busy", k), W'(busy), W'(0));
      chk($sformatf("cmd%0d_clr_err", k), W'(err), W'(0));
    end

    // Accumulation of two partial tiles, including wraparound.
    for (int k = 0; k < 3; k++) begin
      load_tile(0, 0, 0, 0, accs[k].a);
      load_tile(1, 1, 0, 0, accs[k].b);
      for (int i = 0; i < COLS; i++)
        for (int r = 0; r < DEPTH; r++) model[i][r] = accs[k].e;
      drain(0);
    end

    // start_acc from IDLE still overwrites.
    load_tile(0, 0, 0, 0, 32'd5);
    drain(0);
    load_tile(1, 0, 0, 0, 32'd9);
    drain(0);

    // Gapped load with alternating backpressure on drain.
    load_tile(0, 0, 1, 1, 32'd0);
    drain(1);

    // Reset on the 6th load beat, then a fresh tile.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      bus.in_valid = 1'b1;
      bus.in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_valid", W'(bus.out_valid), W'(0));
    chk("abort_tr", W'(tile_ready), W'(0));
    load_tile(0, 0, 0, 1, 32'd0);
    drain(0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
